// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM init/refresh block: command encodings,
// sequencer state codes and the precharge-all address bit.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT      = 4'b1111;
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 4'd0;
    localparam logic [STATE_W-1:0] ST_POWERUP   = 4'd1;
    localparam logic [STATE_W-1:0] ST_PRECHARGE = 4'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_RP   = 4'd3;
    localparam logic [STATE_W-1:0] ST_INIT_REF  = 4'd4;
    localparam logic [STATE_W-1:0] ST_WAIT_RFC  = 4'd5;
    localparam logic [STATE_W-1:0] ST_LOAD_MODE = 4'd6;
    localparam logic [STATE_W-1:0] ST_WAIT_MRD  = 4'd7;
    localparam logic [STATE_W-1:0] ST_IDLE      = 4'd8;
    localparam logic [STATE_W-1:0] ST_REF_CMD   = 4'd9;
    localparam logic [STATE_W-1:0] ST_REF_WAIT  = 4'd10;

    // Address bit that selects "all banks" on a PRECHARGE
    localparam int A10_BIT = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh timer: free-running interval counter, one-deep pending
// flag and a sticky overrun flag for intervals that expire while a request
// is still outstanding.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk_i,
    input  logic rst_i,            // synchronous clear (reset or lock loss)
    input  logic enable_i,         // counts only after init has completed
    input  logic clear_pending_i,  // the pending request was granted this cycle
    output logic pending_next_o,   // pending flag as it will be after this edge
    output logic overrun_o
);

    localparam int TW = $clog2(max_int(REF_INTERVAL, 2));
    localparam logic [TW-1:0] T_LAST = TW'(REF_INTERVAL - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          wrap_s;

    // Next-state for interval counter, pending and overrun flags
    always_comb begin
        wrap_s    = 1'b0;
        tcnt_d    = TW'(0);
        pending_d = 1'b0;
        overrun_d = 1'b0;
        if (enable_i) begin
            wrap_s = (tcnt_q == T_LAST);
            if (wrap_s) begin
                tcnt_d = TW'(0);
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
            // A fresh expiry wins over a same-cycle grant: a new interval has
            // elapsed, so another refresh is owed.
            if (wrap_s) begin
                pending_d = 1'b1;
            end else if (clear_pending_i) begin
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q;
            end
            overrun_d = overrun_q | (wrap_s & pending_q & ~clear_pending_i);
        end else begin
            tcnt_d    = TW'(0);
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // Timer registers with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q    <= TW'(0);
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_next_o = pending_d;
    assign overrun_o      = overrun_q;

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and periodic refresh requester. Owns the command
// bus during initialisation and during granted refreshes; all outputs are
// registered and derived from the state being entered.
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int                ADDR_W       = 13,
    parameter int                BA_W         = 2,
    parameter int                CLK_MHZ      = 100,
    parameter int                T_POWERUP_US = 200,
    parameter int                T_RP         = 2,
    parameter int                T_RFC        = 7,
    parameter int                T_MRD        = 2,
    parameter int                INIT_REF_CNT = 8,
    parameter int                REF_INTERVAL = 780,
    parameter logic [ADDR_W-1:0] MODE_REG     = 13'h032
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              ref_gnt,
    output logic              sdr_cke,
    output logic [3:0]        sdr_cmd,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [BA_W-1:0]   sdr_ba,
    output logic              cmd_own,
    output logic              init_done,
    output logic              ref_req,
    output logic              ref_done,
    output logic              ref_overrun
);

    localparam int PU_CYC = T_POWERUP_US * CLK_MHZ;
    localparam int CNT_W  = $clog2(max_int(max_int(PU_CYC, T_RFC), max_int(max_int(T_RP, T_MRD), 2)));
    localparam int RC_W   = $clog2(INIT_REF_CNT + 1);

    // Wait states last T-1 cycles, so they terminate at count T-2
    localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(PU_CYC - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(max_int(T_RP - 2, 0));
    localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(max_int(T_RFC - 2, 0));
    localparam logic [CNT_W-1:0] MRD_LAST = CNT_W'(max_int(T_MRD - 2, 0));
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(INIT_REF_CNT);

    logic                lock_meta_q, lock_sync_q;
    logic                abort_s, gnt_accept_s, pending_next_s;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic                cke_q, cke_d, own_q, own_d, done_q, done_d;
    logic                req_q, req_d, rdone_q, rdone_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BA_W-1:0]     ba_q, ba_d;

    assign abort_s      = rst | ~lock_sync_q;
    assign gnt_accept_s = req_q & ref_gnt;

    // Two-flop resynchroniser for the PLL lock
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
        end
    end

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .clk_i           (clk),
        .rst_i           (abort_s),
        .enable_i        (done_q),
        .clear_pending_i (gnt_accept_s),
        .pending_next_o  (pending_next_s),
        .overrun_o       (ref_overrun)
    );

    // Sequencer next-state and cycle/refresh counters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                state_d = ST_POWERUP;
                cnt_d   = CNT_W'(0);
            end
            ST_POWERUP: begin
                if (cnt_q == PU_LAST) begin
                    state_d = ST_PRECHARGE;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = ST_POWERUP;
                end
            end
            ST_PRECHARGE: begin
                cnt_d  = CNT_W'(0);
                rcnt_d = RC_W'(0);
                if (T_RP > 1) begin
                    state_d = ST_WAIT_RP;
                end else begin
                    state_d = ST_INIT_REF;
                end
            end
            ST_WAIT_RP: begin
                if (cnt_q == RP_LAST) begin
                    state_d = ST_INIT_REF;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = ST_WAIT_RP;
                end
            end
            ST_INIT_REF: begin
                cnt_d  = CNT_W'(0);
                rcnt_d = rcnt_q + RC_W'(1);
                if (T_RFC > 1) begin
                    state_d = ST_WAIT_RFC;
                end else if (rcnt_d == RC_LAST) begin
                    state_d = ST_LOAD_MODE;
                end else begin
                    state_d = ST_INIT_REF;
                end
            end
            ST_WAIT_RFC: begin
                if (cnt_q == RFC_LAST) begin
                    cnt_d = CNT_W'(0);
                    if (rcnt_q == RC_LAST) begin
                        state_d = ST_LOAD_MODE;
                    end else begin
                        state_d = ST_INIT_REF;
                    end
                end else begin
                    state_d = ST_WAIT_RFC;
                end
            end
            ST_LOAD_MODE: begin
                cnt_d = CNT_W'(0);
                if (T_MRD > 1) begin
                    state_d = ST_WAIT_MRD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_MRD: begin
                if (cnt_q == MRD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = ST_WAIT_MRD;
                end
            end
            ST_IDLE: begin
                cnt_d = CNT_W'(0);
                if (gnt_accept_s) begin
                    state_d = ST_REF_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REF_CMD: begin
                cnt_d = CNT_W'(0);
                if (T_RFC > 1) begin
                    state_d = ST_REF_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REF_WAIT: begin
                if (cnt_q == RFC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = ST_REF_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = CNT_W'(0);
                rcnt_d  = RC_W'(0);
            end
        endcase
    end

    // Bus and status values for the cycle being entered
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        addr_d = ADDR_W'(0);
        ba_d   = BA_W'(0);
        own_d  = 1'b1;
        case (state_d)
            ST_WAIT_LOCK: begin
                cke_d = 1'b0;
                cmd_d = CMD_INHIBIT;
            end
            ST_PRECHARGE: begin
                cmd_d           = CMD_PRECHARGE;
                addr_d[A10_BIT] = 1'b1;
            end
            ST_INIT_REF, ST_REF_CMD: begin
                cmd_d = CMD_AUTO_REFRESH;
            end
            ST_LOAD_MODE: begin
                cmd_d  = CMD_LOAD_MODE;
                addr_d = MODE_REG;
            end
            ST_IDLE: begin
                own_d = 1'b0;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
        done_d  = (state_d == ST_IDLE) || (state_d == ST_REF_CMD) || (state_d == ST_REF_WAIT);
        rdone_d = (state_d == ST_IDLE) && ((state_q == ST_REF_CMD) || (state_q == ST_REF_WAIT));
        req_d   = pending_next_s && (state_d == ST_IDLE);
    end

    // State, counters and registered outputs; reset or lock loss aborts
    always_ff @(posedge clk) begin
        if (abort_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= CNT_W'(0);
            rcnt_q  <= RC_W'(0);
            cke_q   <= 1'b0;
            cmd_q   <= CMD_INHIBIT;
            addr_q  <= ADDR_W'(0);
            ba_q    <= BA_W'(0);
            own_q   <= 1'b1;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            rdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            own_q   <= own_d;
            done_q  <= done_d;
            req_q   <= req_d;
            rdone_q <= rdone_d;
        end
    end

    assign sdr_cke   = cke_q;
    assign sdr_cmd   = cmd_q;
    assign sdr_addr  = addr_q;
    assign sdr_ba    = ba_q;
    assign cmd_own   = own_q;
    assign init_done = done_q;
    assign ref_req   = req_q;
    assign ref_done  = rdone_q;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Bench for sdram_init_refresh: table-driven init sequence, hand-written
// refresh/overrun/abort sequences, then randomized stimulus against a
// timeline-based reference model.
module tb_sdram_init_refresh;

    localparam int PU       = 100;
    localparam int T_RP     = 2;
    localparam int T_RFC    = 7;
    localparam int T_MRD    = 2;
    localparam int NREF     = 8;
    localparam int RI       = 50;
    localparam int REF0     = PU + T_RP;
    localparam int LMR_AT   = REF0 + NREF * T_RFC;
    localparam int INIT_END = LMR_AT + T_MRD;

    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_AR  = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        rst, pll_lock, ref_gnt;
    logic        sdr_cke, cmd_own, init_done, ref_req, ref_done, ref_overrun;
    logic [3:0]  sdr_cmd;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;

    int errors = 0;
    int checks = 0;
    int rel    = 0;
    int rdone_seen = 0;

    always #5 clk = ~clk;

    sdram_init_refresh #(
        .CLK_MHZ      (100),
        .T_POWERUP_US (1),
        .REF_INTERVAL (RI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .ref_gnt     (ref_gnt),
        .sdr_cke     (sdr_cke),
        .sdr_cmd     (sdr_cmd),
        .sdr_addr    (sdr_addr),
        .sdr_ba      (sdr_ba),
        .cmd_own     (cmd_own),
        .init_done   (init_done),
        .ref_req     (ref_req),
        .ref_done    (ref_done),
        .ref_overrun (ref_overrun)
    );

    typedef struct {
        int          rel;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic        own;
        logic        done;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        if (ref_done === 1'b1) rdone_seen++;
    endtask

    function automatic logic [24:0] pack(input logic cke, input logic [3:0] cmd, input logic [12:0] addr,
                                          input logic own, input logic done, input logic req,
                                          input logic rdone, input logic ovr);
        return {cke, cmd, addr, 2'b00, own, done, req, rdone, ovr};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " all"},
              {sdr_cke, sdr_cmd, sdr_addr, sdr_ba, cmd_own, init_done, ref_req, ref_done, ref_overrun},
              pack(1'b0, C_INH, 13'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic wait_powerup(input string tag, output int n);
        n = 0;
        while (sdr_cke !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, " powerup start"}, {sdr_cke, sdr_cmd, cmd_own}, {1'b1, C_NOP, 1'b1});
        rel = 0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 14; i++) begin
            while (rel < tbl[i].rel) tick();
            check($sformatf("%s rel%0d bus", tag, tbl[i].rel),
                  {sdr_cke, sdr_cmd, sdr_addr, cmd_own, init_done},
                  {1'b1, tbl[i].cmd, tbl[i].addr, tbl[i].own, tbl[i].done});
        end
    endtask

    // ---------------- reference model (timeline arithmetic) ----------------
    logic m_l1, m_l2, m_pend, m_ovr, m_req;
    int   m_t, m_rf;
    logic [24:0] m_exp;

    task automatic model_step(input logic r, input logic lk, input logic g);
        logic        abort, prev_req, gr, rdone;
        logic [3:0]  cmd;
        logic [12:0] addr;
        int          k;
        abort = r || !m_l2;
        if (r) begin
            m_l2 = 1'b0;
            m_l1 = 1'b0;
        end else begin
            m_l2 = m_l1;
            m_l1 = lk;
        end
        if (abort) begin
            m_t = -1; m_pend = 1'b0; m_ovr = 1'b0; m_rf = -1; m_req = 1'b0;
            m_exp = pack(1'b0, C_INH, 13'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        prev_req = m_req;
        m_t = (m_t < 0) ? 0 : m_t + 1;
        if (m_t < INIT_END) begin
            cmd = C_NOP;
            addr = 13'h0;
            if (m_t == PU) begin
                cmd = C_PRE;
                addr = 13'h400;
            end else if (m_t >= REF0 && m_t < LMR_AT && ((m_t - REF0) % T_RFC) == 0) begin
                cmd = C_AR;
            end else if (m_t == LMR_AT) begin
                cmd = C_LMR;
                addr = 13'h032;
            end
            m_req = 1'b0;
            m_exp = pack(1'b1, cmd, addr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        k = m_t - INIT_END;
        rdone = 1'b0;
        if (m_rf >= 0) begin
            m_rf++;
            if (m_rf == T_RFC) begin
                m_rf = -1;
                rdone = 1'b1;
            end
        end
        gr = prev_req && g;
        if (k > 0 && (k % RI) == 0) begin
            if (m_pend && !gr) m_ovr = 1'b1;
            m_pend = 1'b1;
        end else if (gr) begin
            m_pend = 1'b0;
        end
        if (gr) m_rf = 0;
        m_req = m_pend && (m_rf < 0);
        m_exp = pack(1'b1, (m_rf == 0) ? C_AR : C_NOP, 13'h0, m_rf >= 0, 1'b1, m_req, rdone, m_ovr);
    endtask

    // Watchdog so the run always ends
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_ar, gmode, lock_hold;
        tbl[0]  = '{0,       C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[1]  = '{99,      C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[2]  = '{100,     C_PRE, 13'h400, 1'b1, 1'b0};
        tbl[3]  = '{101,     C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[4]  = '{102,     C_AR,  13'h000, 1'b1, 1'b0};
        tbl[5]  = '{103,     C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[6]  = '{108,     C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[7]  = '{109,     C_AR,  13'h000, 1'b1, 1'b0};
        tbl[8]  = '{144,     C_AR,  13'h000, 1'b1, 1'b0};
        tbl[9]  = '{151,     C_AR,  13'h000, 1'b1, 1'b0};
        tbl[10] = '{152,     C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[11] = '{158,     C_LMR, 13'h032, 1'b1, 1'b0};
        tbl[12] = '{159,     C_NOP, 13'h000, 1'b1, 1'b0};
        tbl[13] = '{160,     C_NOP, 13'h000, 1'b0, 1'b1};

        // Reset and no-lock behaviour
        rst = 1'b1; pll_lock = 1'b0; ref_gnt = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        repeat (2) tick();
        check_reset("no lock");

        // Lock rise, full init sequence from the table
        pll_lock = 1'b1;
        wait_powerup("lock", n);
        check("lock latency 2..3", (n >= 2 && n <= 3), 1);
        run_table("init");

        // Refresh with grant tied high
        ref_gnt = 1'b1;
        while (rel < INIT_END + RI - 1) tick();
        check("req before interval", ref_req, 1'b0);
        tick();
        check("req at interval", ref_req, 1'b1);
        tick();
        check("AR after grant", {sdr_cmd, cmd_own, ref_req}, {C_AR, 1'b1, 1'b0});
        while (rel < INIT_END + RI + 7) tick();
        check("rfc wait", {sdr_cmd, cmd_own, ref_done}, {C_NOP, 1'b1, 1'b0});
        tick();
        check("ref_done pulse", {ref_done, cmd_own}, {1'b1, 1'b0});
        tick();
        check("ref_done one cycle", ref_done, 1'b0);

        // Grant held low: overrun at second expiry, late grant gives one AR
        ref_gnt = 1'b0;
        while (rel < INIT_END + 2 * RI) tick();
        check("req pending again", ref_req, 1'b1);
        while (rel < INIT_END + 3 * RI - 1) tick();
        check("overrun before 2nd expiry", ref_overrun, 1'b0);
        tick();
        check("overrun at 2nd expiry", {ref_overrun, ref_req}, {1'b1, 1'b1});
        n_ar = 0;
        while (rel < 380) begin
            tick();
            if (sdr_cmd === C_AR) n_ar++;
        end
        check("no AR while ungranted", n_ar, 0);
        check("req still high", ref_req, 1'b1);
        ref_gnt = 1'b1;
        tick();
        ref_gnt = 1'b0;
        n_ar = (sdr_cmd === C_AR) ? 1 : 0;
        while (rel < 395) begin
            tick();
            if (sdr_cmd === C_AR) n_ar++;
        end
        check("req low after service", ref_req, 1'b0);
        ref_gnt = 1'b1;
        tick();
        ref_gnt = 1'b0;
        check("stray gnt idle", {sdr_cmd, cmd_own}, {C_NOP, 1'b0});
        if (sdr_cmd === C_AR) n_ar++;
        while (rel < 409) begin
            tick();
            if (sdr_cmd === C_AR) n_ar++;
        end
        check("late grant single AR", n_ar, 1);
        check("overrun sticky", ref_overrun, 1'b1);

        // Lock loss from idle, then lock loss mid INIT_REF and rerun
        pll_lock = 1'b0;
        repeat (3) tick();
        check_reset("lockloss idle");
        pll_lock = 1'b1;
        wait_powerup("relock1", n);
        while (rel < 120) tick();
        check("mid initref", {sdr_cke, init_done}, {1'b1, 1'b0});
        pll_lock = 1'b0;
        repeat (3) tick();
        check_reset("lockloss initref");
        pll_lock = 1'b1;
        wait_powerup("relock2", n);
        run_table("relock");

        // Reset pulse during REF_WAIT
        ref_gnt = 1'b1;
        while (rel < INIT_END + RI + 1) tick();
        check("AR before rst", sdr_cmd, C_AR);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst in refwait");
        rdone_seen = 0;
        wait_powerup("post rst", n);
        repeat (5) tick();
        check("gnt in powerup", {sdr_cmd, cmd_own, ref_req}, {C_NOP, 1'b1, 1'b0});
        check("no ref_done after rst", rdone_seen, 0);

        // Randomized phase against the reference model
        ref_gnt = 1'b0;
        rst = 1'b1;
        model_step(rst, pll_lock, ref_gnt);
        tick();
        check("model rst", {sdr_cke, sdr_cmd, sdr_addr, sdr_ba, cmd_own, init_done, ref_req, ref_done, ref_overrun}, m_exp);
        rst = 1'b0;
        pll_lock = 1'b1;
        gmode = 0;
        lock_hold = 0;
        for (int c = 0; c < 6000; c++) begin
            if (lock_hold > 0) begin
                lock_hold--;
                if (lock_hold == 0) pll_lock = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                pll_lock = 1'b0;
                lock_hold = $urandom_range(1, 4);
            end
            rst = ($urandom_range(0, 1499) == 0);
            if (c % 150 == 0) gmode = $urandom_range(0, 2);
            ref_gnt = (gmode == 0) ? 1'b0 : (gmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            model_step(rst, pll_lock, ref_gnt);
            tick();
            check($sformatf("model cyc%0d", c),
                  {sdr_cke, sdr_cmd, sdr_addr, sdr_ba, cmd_own, init_done, ref_req, ref_done, ref_overrun},
                  m_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
